// File: rtl/decoder_onehot_q.sv
// decoder_onehot_q: binary index -> one-hot decoder that ORs beats into a multi-hot mask, queued in a DEPTH-entry FIFO.
// Latency: a closing beat accepted at edge N is visible on out_valid/out_mask right after edge N (registered, no bypass).
// Backpressure: in_ready = !full from registered occupancy only; a full FIFO blocks the push even when popped that cycle.
// Optional macro DEC_RANGE_ERR_EN adds a sticky per-mask out-of-range error bit and the out_err port.
module decoder_onehot_q #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 4,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_W-1:0]              in_idx,
    input  logic                         in_acc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             out_mask,
    output logic [$clog2(DEPTH+1)-1:0]   out_level
`ifdef DEC_RANGE_ERR_EN
    ,
    output logic                         out_err
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_OPEN  = 1'b1
    } state_t;

    // Parameter sanity: the mask cannot be wider than the index can address.
    if (OUT_W < 1 || OUT_W > (1 << IN_W)) begin : g_bad_out_w
        $error("decoder_onehot_q: OUT_W must be in 1..2**IN_W");
    end

    state_t             r_state;
    logic [OUT_W-1:0]   r_acc;
    logic [OUT_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [LVL_W-1:0]   r_level;

    logic [OUT_W-1:0]   w_dec;
    logic [OUT_W-1:0]   w_merged;
    logic               w_full;
    logic               w_fire;
    logic               w_push;
    logic               w_pop;

    // Decode the index; out-of-range indices contribute nothing.
    always_comb begin
        w_dec = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (in_idx == IN_W'(i)) begin
                w_dec[i] = 1'b1;
            end
        end
    end

    // An EMPTY accumulator contributes nothing to the merged mask.
    assign w_merged  = ((r_state == S_OPEN) ? r_acc : '0) | w_dec;
    assign w_full    = (r_level == LVL_W'(DEPTH));
    assign in_ready  = !w_full;
    assign out_valid = (r_level != '0);
    assign w_fire    = in_valid && in_ready;
    assign w_push    = w_fire && !in_acc;
    assign w_pop     = out_valid && out_ready;
    assign out_level = r_level;
    // Gate the head with valid so an empty queue always shows a zero mask.
    assign out_mask  = out_valid ? r_mem[r_rptr] : '0;

`ifdef DEC_RANGE_ERR_EN
    logic               r_acc_err;
    logic               r_mem_err [DEPTH];
    logic               w_oor;
    logic               w_merged_err;

    assign w_oor        = (int'(in_idx) >= OUT_W);
    assign w_merged_err = ((r_state == S_OPEN) && r_acc_err) || w_oor;
    assign out_err      = out_valid ? r_mem_err[r_rptr] : 1'b0;

    // Sticky error bit follows the accumulator: set by an out-of-range beat, cleared on close.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_err <= 1'b0;
        end else if (w_fire) begin
            r_acc_err <= in_acc ? w_merged_err : 1'b0;
        end
    end

    // Error storage is written alongside the mask entry.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_err[r_wptr] <= w_merged_err;
        end
    end
`endif

    // Accumulator FSM: merging beats keep it OPEN, a closing beat empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_acc   <= '0;
        end else if (w_fire) begin
            if (in_acc) begin
                r_state <= S_OPEN;
                r_acc   <= w_merged;
            end else begin
                r_state <= S_EMPTY;
                r_acc   <= '0;
            end
        end
    end

    // Mask storage needs no reset; validity is tracked by the occupancy count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_merged;
        end
    end

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work; level tracks push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
